// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time/date/alarm edit controller:
// FSM states, field packing, field ranges, field codes and snapshot clean-up.
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT_CLK,
    S_EDIT_ALM,
    S_COMMIT_CLK,
    S_COMMIT_ALM
  } state_t;

  // Time packing {hour, min, sec}
  localparam int unsigned HOUR_MSB  = 16;
  localparam int unsigned HOUR_LSB  = 12;
  localparam int unsigned MIN_MSB   = 11;
  localparam int unsigned MIN_LSB   = 6;
  localparam int unsigned SEC_MSB   = 5;
  localparam int unsigned SEC_LSB   = 0;

  // Date packing {year, month, day}
  localparam int unsigned YEAR_MSB  = 15;
  localparam int unsigned YEAR_LSB  = 9;
  localparam int unsigned MONTH_MSB = 8;
  localparam int unsigned MONTH_LSB = 5;
  localparam int unsigned DAY_MSB   = 4;
  localparam int unsigned DAY_LSB   = 0;

  // Field ranges (inclusive)
  localparam int unsigned HOUR_MIN  = 0;
  localparam int unsigned HOUR_MAX  = 23;
  localparam int unsigned MIN_MIN   = 0;
  localparam int unsigned MIN_MAX   = 59;
  localparam int unsigned SEC_MIN   = 0;
  localparam int unsigned SEC_MAX   = 59;
  localparam int unsigned YEAR_MIN  = 0;
  localparam int unsigned YEAR_MAX  = 99;
  localparam int unsigned MONTH_MIN = 1;
  localparam int unsigned MONTH_MAX = 12;
  localparam int unsigned DAY_MIN   = 1;
  localparam int unsigned DAY_MAX   = 31;

  // Field index codes shown on EDIT_FIELD
  localparam logic [2:0] F_HOUR  = 3'd0;
  localparam logic [2:0] F_MIN   = 3'd1;
  localparam logic [2:0] F_SEC   = 3'd2;
  localparam logic [2:0] F_YEAR  = 3'd3;
  localparam logic [2:0] F_MONTH = 3'd4;
  localparam logic [2:0] F_DAY   = 3'd5;

  localparam logic [16:0] RESET_TIME = '0;
  localparam logic [15:0] RESET_DATE = 16'h2021;  // year 16, month 1, day 1

  // Replace any out-of-range time field by its minimum.
  function automatic logic [16:0] sanitize_time(input logic [16:0] t);
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    h = t[HOUR_MSB:HOUR_LSB];
    m = t[MIN_MSB:MIN_LSB];
    s = t[SEC_MSB:SEC_LSB];
    if (h > 5'(HOUR_MAX)) h = 5'(HOUR_MIN);
    if (m > 6'(MIN_MAX))  m = 6'(MIN_MIN);
    if (s > 6'(SEC_MAX))  s = 6'(SEC_MIN);
    return {h, m, s};
  endfunction

  // Replace any out-of-range date field by its minimum.
  function automatic logic [15:0] sanitize_date(input logic [15:0] d);
    logic [6:0] y;
    logic [3:0] mo;
    logic [4:0] dy;
    y  = d[YEAR_MSB:YEAR_LSB];
    mo = d[MONTH_MSB:MONTH_LSB];
    dy = d[DAY_MSB:DAY_LSB];
    if (y > 7'(YEAR_MAX)) y = 7'(YEAR_MIN);
    if (mo < 4'(MONTH_MIN) || mo > 4'(MONTH_MAX)) mo = 4'(MONTH_MIN);
    if (dy < 5'(DAY_MIN)) dy = 5'(DAY_MIN);
    return {y, mo, dy};
  endfunction

endpackage

// File: rtl/time_set_ctrl_field_wrap_step.sv
// Single-field increment/decrement with wrap-around in both directions.
module field_wrap_step
  import time_set_ctrl_pkg::*;
(
  input  logic [6:0] value_i,
  input  logic [6:0] min_i,
  input  logic [6:0] max_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [6:0] value_o
);

  // Step one unit; simultaneous up and down leave the value untouched.
  always_comb begin
    value_o = value_i;
    if (up_i && !down_i) begin
      value_o = (value_i >= max_i) ? min_i : value_i + 7'd1;
    end else if (down_i && !up_i) begin
      value_o = (value_i <= min_i) ? max_i : value_i - 7'd1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Edit controller: shadow-register editing of time/date/alarm with commit
// handshake to the time calculator, idle auto-cancel and ack timeout.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 3000000,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned TMR_W        = 22
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        BTN_EDIT,
  input  logic        BTN_ALARM,
  input  logic        BTN_NEXT,
  input  logic        BTN_UP,
  input  logic        BTN_DOWN,
  input  logic        BTN_OK,
  input  logic        BTN_CANCEL,
  input  logic [16:0] CUR_TIME,
  input  logic [15:0] CUR_DATE,
  input  logic        SETTING_OK,
  output logic [16:0] SET_TIME,
  output logic [15:0] SET_DATE,
  output logic [16:0] SET_ALARM,
  output logic        SETTING,
  output logic        ALARM_SETTING,
  output logic        MODE,
  output logic        MODE_STATE,
  output logic [2:0]  EDIT_FIELD,
  output logic        ACK_ERR
);

  localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [16:0]       set_time_q, set_time_d;
  logic [15:0]       set_date_q, set_date_d;
  logic [16:0]       set_alarm_q, set_alarm_d;
  logic [16:0]       alarm_bak_q, alarm_bak_d;
  logic [2:0]        field_q, field_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              setting_q, setting_d;
  logic              alarm_setting_q, alarm_setting_d;
  logic              ack_err_q, ack_err_d;

  logic [16:0]       edit_src;
  logic [6:0]        step_val, step_min, step_max, step_next;
  logic              any_btn, in_edit, idle_expired, ack_expired;

  assign any_btn      = |{BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN, BTN_OK, BTN_CANCEL};
  assign in_edit      = (state_q == S_EDIT_CLK) || (state_q == S_EDIT_ALM);
  assign idle_expired = (tmr_q == IDLE_LAST) && !any_btn;
  assign ack_expired  = (tmr_q == ACK_LAST);

  // Select the field under edit with its range for the shared stepper.
  always_comb begin
    edit_src = (state_q == S_EDIT_ALM) ? set_alarm_q : set_time_q;
    step_val = '0;
    step_min = '0;
    step_max = '0;
    case (field_q)
      F_HOUR: begin
        step_val = {2'b00, edit_src[HOUR_MSB:HOUR_LSB]};
        step_min = 7'(HOUR_MIN);
        step_max = 7'(HOUR_MAX);
      end
      F_MIN: begin
        step_val = {1'b0, edit_src[MIN_MSB:MIN_LSB]};
        step_min = 7'(MIN_MIN);
        step_max = 7'(MIN_MAX);
      end
      F_SEC: begin
        step_val = {1'b0, edit_src[SEC_MSB:SEC_LSB]};
        step_min = 7'(SEC_MIN);
        step_max = 7'(SEC_MAX);
      end
      F_YEAR: begin
        step_val = set_date_q[YEAR_MSB:YEAR_LSB];
        step_min = 7'(YEAR_MIN);
        step_max = 7'(YEAR_MAX);
      end
      F_MONTH: begin
        step_val = {3'b000, set_date_q[MONTH_MSB:MONTH_LSB]};
        step_min = 7'(MONTH_MIN);
        step_max = 7'(MONTH_MAX);
      end
      F_DAY: begin
        step_val = {2'b00, set_date_q[DAY_MSB:DAY_LSB]};
        step_min = 7'(DAY_MIN);
        step_max = 7'(DAY_MAX);
      end
      default: ;
    endcase
  end

  field_wrap_step u_step (
    .value_i (step_val),
    .min_i   (step_min),
    .max_i   (step_max),
    .up_i    (BTN_UP),
    .down_i  (BTN_DOWN),
    .value_o (step_next)
  );

  // Next-state, shadow register updates, timeout counter and request outputs.
  always_comb begin
    state_d     = state_q;
    set_time_d  = set_time_q;
    set_date_d  = set_date_q;
    set_alarm_d = set_alarm_q;
    alarm_bak_d = alarm_bak_q;
    field_d     = field_q;
    ack_err_d   = ack_err_q;

    case (state_q)
      S_IDLE: begin
        if (BTN_EDIT) begin
          set_time_d = sanitize_time(CUR_TIME);
          set_date_d = sanitize_date(CUR_DATE);
          field_d    = F_HOUR;
          state_d    = S_EDIT_CLK;
        end else if (BTN_ALARM) begin
          field_d = F_HOUR;
          state_d = S_EDIT_ALM;
        end
      end

      S_EDIT_CLK, S_EDIT_ALM: begin
        if (BTN_CANCEL || idle_expired) begin
          if (state_q == S_EDIT_ALM) set_alarm_d = alarm_bak_q;
          state_d = S_IDLE;
        end else if (BTN_OK) begin
          state_d = (state_q == S_EDIT_CLK) ? S_COMMIT_CLK : S_COMMIT_ALM;
        end else if (BTN_NEXT) begin
          if (field_q == ((state_q == S_EDIT_CLK) ? F_DAY : F_SEC)) field_d = F_HOUR;
          else field_d = field_q + 3'd1;
        end else if (BTN_UP != BTN_DOWN) begin
          if (state_q == S_EDIT_ALM) begin
            case (field_q)
              F_HOUR:  set_alarm_d[HOUR_MSB:HOUR_LSB] = step_next[4:0];
              F_MIN:   set_alarm_d[MIN_MSB:MIN_LSB]   = step_next[5:0];
              F_SEC:   set_alarm_d[SEC_MSB:SEC_LSB]   = step_next[5:0];
              default: ;
            endcase
          end else begin
            case (field_q)
              F_HOUR:  set_time_d[HOUR_MSB:HOUR_LSB]   = step_next[4:0];
              F_MIN:   set_time_d[MIN_MSB:MIN_LSB]     = step_next[5:0];
              F_SEC:   set_time_d[SEC_MSB:SEC_LSB]     = step_next[5:0];
              F_YEAR:  set_date_d[YEAR_MSB:YEAR_LSB]   = step_next;
              F_MONTH: set_date_d[MONTH_MSB:MONTH_LSB] = step_next[3:0];
              F_DAY:   set_date_d[DAY_MSB:DAY_LSB]     = step_next[4:0];
              default: ;
            endcase
          end
        end
      end

      S_COMMIT_CLK, S_COMMIT_ALM: begin
        if (SETTING_OK) begin
          if (state_q == S_COMMIT_ALM) alarm_bak_d = set_alarm_q;
          ack_err_d = 1'b0;
          state_d   = S_IDLE;
        end else if (ack_expired) begin
          // An unacknowledged alarm never became the live alarm, so show the old one again.
          if (state_q == S_COMMIT_ALM) set_alarm_d = alarm_bak_q;
          ack_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // One counter serves both the idle timeout (edit) and the ack timeout (commit);
    // buttons only restart it while editing since they are ignored during commit.
    if (state_d != state_q || state_q == S_IDLE) tmr_d = '0;
    else if (in_edit && any_btn)                 tmr_d = '0;
    else                                         tmr_d = tmr_q + TMR_W'(1);

    setting_d       = (state_d == S_COMMIT_CLK);
    alarm_setting_d = (state_d == S_COMMIT_ALM);
  end

  // State and shadow registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q         <= S_IDLE;
      set_time_q      <= RESET_TIME;
      set_date_q      <= RESET_DATE;
      set_alarm_q     <= '0;
      alarm_bak_q     <= '0;
      field_q         <= '0;
      tmr_q           <= '0;
      setting_q       <= 1'b0;
      alarm_setting_q <= 1'b0;
      ack_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      set_time_q      <= set_time_d;
      set_date_q      <= set_date_d;
      set_alarm_q     <= set_alarm_d;
      alarm_bak_q     <= alarm_bak_d;
      field_q         <= field_d;
      tmr_q           <= tmr_d;
      setting_q       <= setting_d;
      alarm_setting_q <= alarm_setting_d;
      ack_err_q       <= ack_err_d;
    end
  end

  assign SET_TIME      = set_time_q;
  assign SET_DATE      = set_date_q;
  assign SET_ALARM     = set_alarm_q;
  assign SETTING       = setting_q;
  assign ALARM_SETTING = alarm_setting_q;
  assign MODE          = (state_q != S_IDLE);
  assign MODE_STATE    = (state_q == S_EDIT_ALM) || (state_q == S_COMMIT_ALM);
  assign EDIT_FIELD    = field_q;
  assign ACK_ERR       = ack_err_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: directed scenarios plus random button
// traffic, checked every cycle against a field-level behavioural model.
module tb_time_set_ctrl;

  localparam int unsigned IT = 100;
  localparam int unsigned AT = 16;

  localparam logic [6:0] B_NONE   = 7'b0000000;
  localparam logic [6:0] B_EDIT   = 7'b1000000;
  localparam logic [6:0] B_ALARM  = 7'b0100000;
  localparam logic [6:0] B_NEXT   = 7'b0010000;
  localparam logic [6:0] B_UP     = 7'b0001000;
  localparam logic [6:0] B_DOWN   = 7'b0000100;
  localparam logic [6:0] B_OK     = 7'b0000010;
  localparam logic [6:0] B_CANCEL = 7'b0000001;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN, BTN_OK, BTN_CANCEL;
  logic [16:0] CUR_TIME;
  logic [15:0] CUR_DATE;
  logic        SETTING_OK;
  logic [16:0] SET_TIME;
  logic [15:0] SET_DATE;
  logic [16:0] SET_ALARM;
  logic        SETTING, ALARM_SETTING, MODE, MODE_STATE, ACK_ERR;
  logic [2:0]  EDIT_FIELD;

  time_set_ctrl #(.IDLE_TIMEOUT(IT), .ACK_TIMEOUT(AT), .TMR_W(22)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .BTN_EDIT(BTN_EDIT), .BTN_ALARM(BTN_ALARM), .BTN_NEXT(BTN_NEXT),
    .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_OK(BTN_OK), .BTN_CANCEL(BTN_CANCEL),
    .CUR_TIME(CUR_TIME), .CUR_DATE(CUR_DATE), .SETTING_OK(SETTING_OK),
    .SET_TIME(SET_TIME), .SET_DATE(SET_DATE), .SET_ALARM(SET_ALARM),
    .SETTING(SETTING), .ALARM_SETTING(ALARM_SETTING), .MODE(MODE),
    .MODE_STATE(MODE_STATE), .EDIT_FIELD(EDIT_FIELD), .ACK_ERR(ACK_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16:0] st;
    logic [15:0] sd;
    logic [16:0] sa;
    logic        setting;
    logic        asetting;
    logic        mode;
    logic        mstate;
    logic        ack_err;
    logic [2:0]  fld;
    logic        chk_fld;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 edit clock, 2 edit alarm, 3 commit clock, 4 commit alarm
  int md, fld, tmr;
  int tv[6];      // hour, min, sec, year, month, day
  int av[3];      // alarm shadow
  int ab[3];      // last committed alarm
  bit aerr;
  int lo[6] = '{0, 0, 0, 0, 1, 1};
  int hi[6] = '{23, 59, 59, 99, 12, 31};

  logic [16:0] ct_v;
  logic [15:0] cd_v;

  function automatic int wrap(input int v, input int dlt, input int k);
    int span;
    span = hi[k] - lo[k] + 1;
    return lo[k] + ((v - lo[k] + dlt + span) % span);
  endfunction

  task automatic model_step(input logic [6:0] b, input logic ok, input logic rstn);
    bit e, a, n, u, d, o, c, anyb;
    int raw[6];
    {e, a, n, u, d, o, c} = b;
    anyb = (b != 7'd0);
    if (!rstn) begin
      md = 0; fld = 0; tmr = 0; aerr = 0;
      tv = '{0, 0, 0, 16, 1, 1};
      av = '{0, 0, 0};
      ab = '{0, 0, 0};
      return;
    end
    case (md)
      0: begin
        if (e) begin
          raw[0] = int'(ct_v[16:12]); raw[1] = int'(ct_v[11:6]); raw[2] = int'(ct_v[5:0]);
          raw[3] = int'(cd_v[15:9]);  raw[4] = int'(cd_v[8:5]);  raw[5] = int'(cd_v[4:0]);
          for (int k = 0; k < 6; k++)
            tv[k] = (raw[k] < lo[k] || raw[k] > hi[k]) ? lo[k] : raw[k];
          fld = 0; md = 1; tmr = 0;
        end else if (a) begin
          fld = 0; md = 2; tmr = 0;
        end
      end
      1, 2: begin
        if (c || (tmr == int'(IT) - 1 && !anyb)) begin
          if (md == 2) av = ab;
          md = 0; tmr = 0;
        end else if (o) begin
          md = md + 2; tmr = 0;
        end else begin
          if (n) fld = (fld + 1) % ((md == 1) ? 6 : 3);
          else if (u != d) begin
            if (md == 1) tv[fld] = wrap(tv[fld], u ? 1 : -1, fld);
            else         av[fld] = wrap(av[fld], u ? 1 : -1, fld);
          end
          tmr = anyb ? 0 : tmr + 1;
        end
      end
      default: begin
        if (ok) begin
          if (md == 4) ab = av;
          aerr = 0; md = 0; tmr = 0;
        end else if (tmr == int'(AT) - 1) begin
          if (md == 4) av = ab;
          aerr = 1; md = 0; tmr = 0;
        end else begin
          tmr = tmr + 1;
        end
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.st       = 17'(tv[0] * 4096 + tv[1] * 64 + tv[2]);
    x.sd       = 16'(tv[3] * 512 + tv[4] * 32 + tv[5]);
    x.sa       = 17'(av[0] * 4096 + av[1] * 64 + av[2]);
    x.setting  = (md == 3);
    x.asetting = (md == 4);
    x.mode     = (md != 0);
    x.mstate   = (md == 2 || md == 4);
    x.ack_err  = aerr;
    x.fld      = 3'(fld);
    x.chk_fld  = (md == 1 || md == 2);
    return x;
  endfunction

  // Apply one cycle of stimulus away from the clock edge and queue the expected outputs.
  task automatic drive(input logic [6:0] b, input logic ok, input logic rstn);
    @(negedge CLK);
    {BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN, BTN_OK, BTN_CANCEL} = b;
    SETTING_OK = ok;
    RESETN     = rstn;
    CUR_TIME   = ct_v;
    CUR_DATE   = cd_v;
    model_step(b, ok, rstn);
    q.push_back(model_out());
  endtask

  task automatic press(input logic [6:0] b, input int n);
    for (int i = 0; i < n; i++) drive(b, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  // Monitor: after each active edge, compare DUT outputs with the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("SET_TIME", 32'(SET_TIME), 32'(e.st));
        chk("SET_DATE", 32'(SET_DATE), 32'(e.sd));
        chk("SET_ALARM", 32'(SET_ALARM), 32'(e.sa));
        chk("SETTING", 32'(SETTING), 32'(e.setting));
        chk("ALARM_SETTING", 32'(ALARM_SETTING), 32'(e.asetting));
        chk("MODE", 32'(MODE), 32'(e.mode));
        chk("MODE_STATE", 32'(MODE_STATE), 32'(e.mstate));
        chk("ACK_ERR", 32'(ACK_ERR), 32'(e.ack_err));
        chk("REQ_EXCLUSIVE", 32'(SETTING & ALARM_SETTING), 32'd0);
        if (e.chk_fld) chk("EDIT_FIELD", 32'(EDIT_FIELD), 32'(e.fld));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [6:0] b;
    logic       ok, rst;
    int         r;
    RESETN = 1'b0;
    {BTN_EDIT, BTN_ALARM, BTN_NEXT, BTN_UP, BTN_DOWN, BTN_OK, BTN_CANCEL} = B_NONE;
    SETTING_OK = 1'b0;
    ct_v = '0; cd_v = '0;
    CUR_TIME = '0; CUR_DATE = '0;
    for (int i = 0; i < 3; i++) drive(B_NONE, 1'b0, 1'b0);
    press(B_NONE, 2);

    // Snapshot 23:59:58, 16/12/31 and boundary wraps
    ct_v = 17'(23 * 4096 + 59 * 64 + 58);
    cd_v = 16'(16 * 512 + 12 * 32 + 31);
    press(B_EDIT, 1);
    press(B_UP, 1);      // hour 23 -> 0
    press(B_DOWN, 1);    // hour 0 -> 23
    press(B_NEXT, 6);    // field back to 0
    press(B_NEXT, 4);    // month
    press(B_UP, 1);      // 12 -> 1
    press(B_NEXT, 1);    // day (31)
    press(B_UP, 1);      // 31 -> 1
    press(B_DOWN, 1);    // 1 -> 31
    press(B_NEXT, 2);    // min
    press(B_DOWN, 29);   // 59 -> 30
    press(B_OK, 1);
    press(B_NONE, 2);
    drive(B_NONE, 1'b1, 1'b1);
    press(B_NONE, 2);

    // Alarm commit then cancelled re-edit
    press(B_ALARM, 1);
    press(B_UP, 7);
    press(B_OK, 1);
    press(B_NONE, 1);
    drive(B_NONE, 1'b1, 1'b1);
    press(B_NONE, 1);
    press(B_ALARM, 1);
    press(B_UP, 2);
    press(B_CANCEL, 1);
    press(B_NONE, 1);

    // Clock commit without acknowledge
    press(B_EDIT, 1);
    press(B_OK, 1);
    press(B_NONE, 20);

    // Idle auto-cancel
    press(B_EDIT, 1);
    press(B_NONE, IT + 5);

    // UP and DOWN together
    press(B_EDIT, 1);
    press(B_UP | B_DOWN, 1);
    press(B_NONE, 1);
    press(B_CANCEL, 1);

    // Reset during commit
    press(B_EDIT, 1);
    press(B_OK, 1);
    press(B_NONE, 3);
    drive(B_NONE, 1'b0, 1'b0);
    press(B_NONE, 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 19));
      case (r)
        0:               b = B_EDIT;
        1:               b = B_ALARM;
        2, 3, 4:         b = B_NEXT;
        5, 6, 7, 8, 9:   b = B_UP;
        10, 11, 12, 13:  b = B_DOWN;
        14:              b = 7'($urandom);
        15:              b = B_OK;
        16:              b = B_CANCEL;
        default:         b = B_NONE;
      endcase
      if (md >= 3) b = B_NONE;
      ok = ($urandom_range(0, 4) == 0);
      if (md == 4 && tmr >= int'(AT) - 4) ok = 1'b1;
      rst = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          ct_v = 17'($urandom_range(0, 23) * 4096 + $urandom_range(0, 59) * 64 + $urandom_range(0, 59));
          cd_v = 16'($urandom_range(0, 99) * 512 + $urandom_range(1, 12) * 32 + $urandom_range(1, 31));
        end else begin
          ct_v = 17'($urandom);
          cd_v = 16'($urandom);
        end
      end
      drive(b, ok, rst);
    end

    press(B_NONE, 1);
    @(posedge CLK);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-facing edit controller that sequences clock/date/alarm setting for the time calculator block.
- Takes debounced single-cycle button pulses and a snapshot of the running time and date.
- Lets the user edit one field at a time in shadow registers, then commits by driving SETTING or ALARM_SETTING until the calculator returns SETTING_OK.
- Also drives MODE/MODE_STATE so the display freezes and selects the alarm view while editing.

Parameters:
- IDLE_TIMEOUT, 3000000: cycles with no button press in an edit state before an automatic cancel (30 s at 100 kHz).
- ACK_TIMEOUT, 16: cycles to wait for SETTING_OK after commit before flagging an error.
- TMR_W, 22: width of the shared timeout counter; must hold IDLE_TIMEOUT.

Ports:
- CLK  in  1  clock
- RESETN  in  1  synchronous active-low reset
- BTN_EDIT  in  1  pulse: enter clock/date edit
- BTN_ALARM  in  1  pulse: enter alarm edit
- BTN_NEXT  in  1  pulse: advance to the next field
- BTN_UP  in  1  pulse: increment the current field
- BTN_DOWN  in  1  pulse: decrement the current field
- BTN_OK  in  1  pulse: commit
- BTN_CANCEL  in  1  pulse: abandon edit
- CUR_TIME  in  17  running time {hour[16:12], min[11:6], sec[5:0]}
- CUR_DATE  in  16  running date {year[15:9], month[8:5], day[4:0]}
- SETTING_OK  in  1  acknowledge from the calculator
- SET_TIME  out  17  shadow time, same packing as CUR_TIME
- SET_DATE  out  16  shadow date, same packing as CUR_DATE
- SET_ALARM  out  17  alarm shadow / last committed alarm
- SETTING  out  1  load request for time and date
- ALARM_SETTING  out  1  load request for alarm
- MODE  out  1  1 = display frozen (edit or commit in progress)
- MODE_STATE  out  1  1 = alarm view
- EDIT_FIELD  out  3  field being edited (for blink)
- ACK_ERR  out  1  sticky: commit was not acknowledged

Behaviour:
- Reset is synchronous on CLK, active-low RESETN. Reset values:
  - State IDLE.
  - SET_TIME = 0.
  - SET_DATE = 0x2021 (year 16, month 1, day 1).
  - SET_ALARM = 0.
  - SETTING, ALARM_SETTING, MODE, MODE_STATE, ACK_ERR all 0.
  - EDIT_FIELD = 0; timeout counter = 0.
- States: IDLE, EDIT_CLK, EDIT_ALM, COMMIT_CLK, COMMIT_ALM.
- IDLE:
  - BTN_EDIT: copy CUR_TIME/CUR_DATE into SET_TIME/SET_DATE, set EDIT_FIELD = 0, go to EDIT_CLK.
  - Else BTN_ALARM: keep SET_ALARM as is, set EDIT_FIELD = 0, go to EDIT_ALM.
  - BTN_EDIT wins if both arrive together. All other buttons are ignored.
  - On snapshot, any out-of-range field is replaced by its minimum.
- Field codes:
  - EDIT_CLK: 0 HOUR, 1 MIN, 2 SEC, 3 YEAR, 4 MONTH, 5 DAY.
  - EDIT_ALM: 0 HOUR, 1 MIN, 2 SEC.
- Field ranges, all wrapping both directions:
  - HOUR 0..23; MIN and SEC 0..59; YEAR 0..99; MONTH 1..12; DAY 1..31.
  - UP at max gives min; DOWN at min gives max.
- Button priority in an edit state, one action per cycle: CANCEL > OK > NEXT > UP > DOWN.
  - UP and DOWN in the same cycle: no change.
- NEXT wraps the field index: 5→0 in EDIT_CLK, 2→0 in EDIT_ALM.
- CANCEL: go to IDLE.
  - SET_TIME and SET_DATE keep the edited values but no load request is made.
  - SET_ALARM reverts to its last committed value, so the alarm needs a backup register.
- Timeout counter:
  - Clears on any button pulse and on every state change.
  - Reaching IDLE_TIMEOUT−1 in an edit state behaves as CANCEL on the next cycle.
- OK:
  - From EDIT_CLK go to COMMIT_CLK; from EDIT_ALM go to COMMIT_ALM.
  - Registered request outputs go high in the first cycle of the commit state.
- COMMIT_*:
  - Hold SETTING (or ALARM_SETTING) = 1 and shadow values stable.
  - When SETTING_OK is sampled 1, drop the request next cycle and go to IDLE. ACK_ERR clears on a successful commit.
  - After ACK_TIMEOUT cycles without SETTING_OK: drop the request, set ACK_ERR, go to IDLE.
  - All buttons are ignored in COMMIT_*.
- SET_ALARM's backup copy updates only on a successful COMMIT_ALM.
- MODE = 1 in every state except IDLE. MODE_STATE = 1 in EDIT_ALM and COMMIT_ALM.
- SETTING and ALARM_SETTING are never high together.
- Reset asserted mid-edit or mid-commit returns everything to reset values on the next edge; any request drops immediately.

Decomposition:
- Shared package holds:
  - Field bit-slice constants for time/date packing.
  - Field range min/max constants.
  - State encoding.
  - Field index codes.
  - Reset date constant 0x2021.
- One sub-module, field_wrap_step: combinational.
  - Inputs: value, min, max, up, down.
  - Output: next value with wrap.
  - Instanced once, muxed by EDIT_FIELD.

Test Plan:
- Reset, then BTN_EDIT with CUR_TIME = 23:59:58, CUR_DATE = 16/12/31 → MODE = 1, SET_TIME = {23,59,58}, EDIT_FIELD = 0.
- HOUR = 23, then UP → 0; DOWN → 23. NEXT ×6 → EDIT_FIELD returns to 0. MONTH = 12, UP → 1; DAY = 1, DOWN → 31.
- Edit MIN to 30, then OK → SETTING = 1 from the next cycle. SETTING_OK = 1 three cycles later → SETTING = 0 the cycle after, state IDLE, MODE = 0.
- BTN_ALARM, set HOUR = 7, OK, ack received → SET_ALARM = {7,0,0}, MODE_STATE = 1 during the edit. Re-enter, set HOUR = 9, CANCEL → SET_ALARM = {7,0,0}.
- OK with SETTING_OK held 0 → SETTING high for exactly 16 cycles, then ACK_ERR = 1, IDLE.
- Enter edit, press no button for IDLE_TIMEOUT (override to 100) → IDLE with no request. UP+DOWN together → value unchanged. Reset during COMMIT → SETTING = 0 next edge.
